main_mem_responder: RTL and testbench

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

---
 rtl/main_mem_responder_pkg.sv | 16 +
 rtl/main_mem_responder_if.sv | 26 ++
 rtl/main_mem_responder_mem_array.sv | 28 ++
 rtl/main_mem_responder.sv | 148 ++++++++++++++
 tb/tb_main_mem_responder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/main_mem_responder_pkg.sv
// Shared definitions for the main-memory responder: FSM state encoding and
// default sizing of the backing store, block burst and access latency.
package main_mem_pkg;

    localparam int DEF_DEPTH_WORDS = 1024;
    localparam int DEF_BLOCK_WORDS = 4;
    localparam int DEF_LATENCY     = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/main_mem_responder_if.sv
// Cache-side bus of the main-memory responder: request channel, writeback
// data channel, fill data channel and transaction-complete pulse.
interface main_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        done;

    modport master (
        output req_valid, req_write, req_addr, wdata_valid, wdata,
        input  req_ready, wdata_ready, rdata_valid, rdata, done
    );

    modport slave (
        input  req_valid, req_write, req_addr, wdata_valid, wdata,
        output req_ready, wdata_ready, rdata_valid, rdata, done
    );

endinterface

// File: rtl/main_mem_responder_mem_array.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32, write-enable, registered read.
// Contents are never reset.
module mem_array
    import main_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_q <= r_mem[i_addr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/main_mem_responder.sv
// Main-memory responder serving cache block fills and writebacks after a fixed
// latency. Optional fill/writeback counters are built when MAIN_MEM_STATS_EN is defined.
module main_mem_responder
    import main_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic                 clk,
    input  logic                 reset,
    main_mem_responder_if.slave  bus
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [15:0]          fill_cnt,
    output logic [15:0]          wb_cnt
`endif
);

    localparam int AW   = $clog2(DEPTH_WORDS);
    localparam int BL   = $clog2(BLOCK_WORDS);
    localparam int BW_W = (BL > 0) ? BL : 1;
    localparam int LC_W = $clog2(LATENCY + 1);

    localparam logic [AW-1:0]   BLK_MASK  = ~AW'(BLOCK_WORDS - 1);
    localparam logic [BW_W-1:0] LAST_BEAT = BW_W'(BLOCK_WORDS - 1);
    localparam logic [LC_W-1:0] LAST_WAIT = LC_W'(LATENCY - 1);

    state_t          r_state;
    state_t          w_next;
    logic [LC_W-1:0] r_wait;
    logic [BW_W-1:0] r_beat;
    logic            r_write;
    logic [AW-1:0]   r_base;

    logic [AW-1:0]   w_base;
    logic [AW-1:0]   w_addr;
    logic            w_we;
    logic            w_ready;
    logic            w_rvalid;
    logic            w_wready;
    logic            w_done;
    logic            w_accept;
    logic [31:0]     w_q;
    logic            w_unused_addr;

    assign w_base        = bus.req_addr[AW+1:2] & BLK_MASK;
    assign w_unused_addr = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};
    assign w_accept      = w_ready & bus.req_valid;

    // Fill reads are issued one cycle ahead of the beat they feed, so the
    // registered RAM output lines up with rdata_valid.
    always_comb begin
        w_next   = r_state;
        w_addr   = r_base;
        w_we     = 1'b0;
        w_ready  = 1'b0;
        w_rvalid = 1'b0;
        w_wready = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.req_valid) w_next = WAIT;
            end
            WAIT: begin
                if (r_wait == LAST_WAIT) w_next = XFER;
            end
            XFER: begin
                if (r_write) begin
                    w_wready = 1'b1;
                    w_addr   = r_base + AW'(r_beat);
                    if (bus.wdata_valid) begin
                        w_we = 1'b1;
                        if (r_beat == LAST_BEAT) w_next = DONE;
                    end
                end else begin
                    w_rvalid = 1'b1;
                    w_addr   = r_base + AW'(r_beat) + AW'(1);
                    if (r_beat == LAST_BEAT) w_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_wait  <= '0;
            r_beat  <= '0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    r_wait <= '0;
                    r_beat <= '0;
                    if (w_accept) r_write <= bus.req_write;
                end
                WAIT: r_wait <= r_wait + LC_W'(1);
                XFER: if (w_we || w_rvalid) r_beat <= r_beat + BW_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_base <= w_base;
    end

    mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (bus.wdata),
        .o_rdata (w_q)
    );

    assign bus.req_ready   = w_ready;
    assign bus.wdata_ready = w_wready;
    assign bus.rdata_valid = w_rvalid;
    assign bus.rdata       = w_rvalid ? w_q : 32'h0;
    assign bus.done        = w_done;

`ifdef MAIN_MEM_STATS_EN
    logic [15:0] r_fill_cnt;
    logic [15:0] r_wb_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fill_cnt <= '0;
            r_wb_cnt   <= '0;
        end else if (r_state == DONE) begin
            if (r_write) r_wb_cnt   <= r_wb_cnt + 16'd1;
            else         r_fill_cnt <= r_fill_cnt + 16'd1;
        end
    end

    assign fill_cnt = r_fill_cnt;
    assign wb_cnt   = r_wb_cnt;
`endif

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder (LATENCY=3, BLOCK_WORDS=4, DEPTH_WORDS=1024);
// counter checks are compiled in when MAIN_MEM_STATS_EN is defined.
module tb_main_mem_responder;

    localparam int LAT = 3;
    localparam int BW  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    main_mem_responder_if bus();

`ifdef MAIN_MEM_STATS_EN
    logic [15:0] fill_cnt;
    logic [15:0] wb_cnt;
    int exp_fills = 0;
    int exp_wbs   = 0;
`endif

    main_mem_responder #(.DEPTH_WORDS(1024), .BLOCK_WORDS(BW), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MAIN_MEM_STATS_EN
        ,
        .fill_cnt (fill_cnt),
        .wb_cnt   (wb_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0]      addr;
        logic [3:0][31:0] exp;
    } fill_vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // {req_ready, rdata_valid, wdata_ready, done, rdata}
    function automatic logic [35:0] obs();
        return {bus.req_ready, bus.rdata_valid, bus.wdata_ready, bus.done, bus.rdata};
    endfunction

    task automatic check_fill_cycle(input int j, input fill_vec_t v, input string nm);
        logic [35:0] e;
        if (j >= LAT && j < LAT + BW) e = {4'b0100, v.exp[j-LAT]};
        else if (j == LAT + BW)       e = {4'b0001, 32'h0};
        else if (j == LAT + BW + 1)   e = {4'b1000, 32'h0};
        else                          e = '0;
        check($sformatf("%s cyc%0d", nm, j), 64'(obs()), 64'(e));
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({nm, " ready"}, 64'(bus.req_ready), 64'(1));
    endtask

    task automatic do_fill(input fill_vec_t v, input string nm);
        wait_ready(nm);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = v.addr;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int j = 0; j <= LAT + BW + 1; j++) begin
            @(negedge clk);
            check_fill_cycle(j, v, nm);
        end
`ifdef MAIN_MEM_STATS_EN
        exp_fills++;
`endif
    endtask

    task automatic do_wb(input logic [31:0] addr, input logic [3:0][31:0] d,
                         input int gap_beat, input int gap_len, input string nm);
        int beat = 0;
        int idle = 0;
        wait_ready(nm);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = addr;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        for (int c = 0; c < LAT; c++) begin
            @(negedge clk);
            check($sformatf("%s wait%0d", nm, c),
                  64'({bus.req_ready, bus.wdata_ready, bus.done}), 64'(0));
        end
        while (beat < BW) begin
            @(negedge clk);
            check($sformatf("%s xfer b%0d", nm, beat),
                  64'({bus.req_ready, bus.wdata_ready, bus.done, bus.rdata_valid}), 64'(4'b0100));
            if (beat == gap_beat && idle < gap_len) begin
                bus.wdata_valid = 1'b0;
                idle++;
            end else begin
                bus.wdata_valid = 1'b1;
                bus.wdata       = d[beat];
                beat++;
            end
        end
        @(negedge clk);
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        check({nm, " done"}, 64'({bus.req_ready, bus.wdata_ready, bus.done}), 64'(3'b001));
        @(negedge clk);
        check({nm, " idle"}, 64'({bus.req_ready, bus.wdata_ready, bus.done}), 64'(3'b100));
`ifdef MAIN_MEM_STATS_EN
        exp_wbs++;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_vec_t        fv [5];
        fill_vec_t        hv;
        logic [3:0][31:0] wc, wd, wa, ws;

        wc = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        wd = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        wa = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        ws = {32'h44, 32'h33, 32'h22, 32'h11};
        fv[0] = '{32'h0000_0040, wa};
        fv[1] = '{32'h0000_004C, wa};
        fv[2] = '{32'h0000_0080, ws};
        fv[3] = '{32'h0000_1000, {32'hC3, 32'hC2, 32'hD1, 32'hD0}};
        fv[4] = '{32'h0000_1080, ws};

        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;

        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset outputs", 64'(obs()), 64'(36'h8_0000_0000));
`ifdef MAIN_MEM_STATS_EN
        check("reset counters", 64'({fill_cnt, wb_cnt}), 64'(0));
`endif
        reset = 1'b0;
        @(negedge clk);
        check("idle after reset", 64'(obs()), 64'(36'h8_0000_0000));

        do_wb(32'h0000_0000, wc, BW, 0, "wb0");

        // Writeback aborted by reset after two beats: words 0..1 become D0/D1.
        wait_ready("abort");
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        repeat (LAT) @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            bus.wdata_valid = 1'b1;
            bus.wdata       = wd[b];
        end
        @(negedge clk);
        bus.wdata_valid = 1'b0;
        reset = 1'b1;
        #1 check("abort in reset", 64'({bus.req_ready, bus.wdata_ready, bus.done, bus.rdata_valid}), 64'(4'b1000));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("abort hold%0d", k),
                  64'({bus.req_ready, bus.wdata_ready, bus.done, bus.rdata_valid}), 64'(4'b1000));
        end
        reset = 1'b0;
`ifdef MAIN_MEM_STATS_EN
        exp_fills = 0;
        exp_wbs   = 0;
`endif
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("abort after%0d", k),
                  64'({bus.req_ready, bus.wdata_ready, bus.done, bus.rdata_valid}), 64'(4'b1000));
        end

        do_wb(32'h0000_0040, wa, BW, 0, "wb40");
        do_wb(32'h0000_0080, ws, 2, 2, "wb80 stall");

        for (int i = 0; i < 5; i++) begin
            do_fill(fv[i], $sformatf("fill%0d", i));
`ifdef MAIN_MEM_STATS_EN
            if (i == 2) check("stats 3f2w", 64'({fill_cnt, wb_cnt}), 64'({16'(exp_fills), 16'(exp_wbs)}));
`endif
        end

        // req_valid held through a fill: the next request is taken on the first IDLE cycle.
        wait_ready("hold");
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = fv[0].addr;
        @(posedge clk);
        #1 bus.req_addr = 32'h0000_0080;
        for (int j = 0; j <= LAT + BW + 1; j++) begin
            @(negedge clk);
            check_fill_cycle(j, fv[0], "hold1");
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        hv = '{32'h0000_0080, ws};
        for (int j = 0; j <= LAT + BW + 1; j++) begin
            @(negedge clk);
            check_fill_cycle(j, hv, "hold2");
        end
`ifdef MAIN_MEM_STATS_EN
        exp_fills += 2;
        check("stats final", 64'({fill_cnt, wb_cnt}), 64'({16'(exp_fills), 16'(exp_wbs)}));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
